// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read data and overflow/underflow flags
// Define SYNC_FIFO_COUNT_EN to add the occupancy output port count.
module sync_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic             wr_err,
  output logic             rd_err
`ifdef SYNC_FIFO_COUNT_EN
  ,
  output logic [PTR_WIDTH:0] count
`endif
);

  localparam logic [PTR_WIDTH:0] PTR_ONE = {{PTR_WIDTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0]   rdata_q, rdata_d;
  logic               wr_err_q, wr_err_d;
  logic               rd_err_q, rd_err_d;
  logic               wr_acc, rd_acc;

  // The extra MSB on each pointer tells a full buffer apart from an empty one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                 (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);

  always_comb begin
    wr_acc   = wr_en && !full;
    rd_acc   = rd_en && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rdata_d  = rdata_q;
    wr_err_d = wr_en && full;
    rd_err_d = rd_en && empty;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      rdata_d  = mem_q[rd_ptr_q[PTR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdata_q  <= '0;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdata_q  <= rdata_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[PTR_WIDTH-1:0]] <= wdata;
    end
  end

  assign rdata  = rdata_q;
  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;

`ifdef SYNC_FIFO_COUNT_EN
  assign count = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - scoreboard bench for sync_fifo
module tb_sync_fifo;

  logic       clk;
  logic       rst;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       wr_en;
  logic       rd_en;
  logic       full;
  logic       empty;
  logic       wr_err;
  logic       rd_err;
`ifdef SYNC_FIFO_COUNT_EN
  logic [4:0] count;
`endif

  sync_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .wdata (wdata),
    .rdata (rdata),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .full  (full),
    .empty (empty),
    .wr_err(wr_err),
    .rd_err(rd_err)
`ifdef SYNC_FIFO_COUNT_EN
    ,
    .count (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_pass = 0;
  int         n_total = 0;
  logic [7:0] model_q[$];
  logic [7:0] sb_q[$];
  logic [7:0] last_rdata = 8'h00;
  bit         exp_rd = 1'b0;
  bit         mon_fl;
  bit         prev_full;
  int         full_rises;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: after each edge, pop the next expected word if a read was accepted.
  always begin
    @(posedge clk);
    mon_fl = exp_rd;
    #1;
    if (mon_fl) begin
      if (sb_q.size() == 0) chk("sb_underrun", 1, 0);
      else last_rdata = sb_q.pop_front();
    end
    chk("rdata", {24'h0, rdata}, {24'h0, last_rdata});
  end

  task automatic do_cycle(input bit wr, input logic [7:0] wd, input bit rd);
    bit fm, em;
    @(negedge clk);
    wr_en = wr;
    rd_en = rd;
    wdata = wd;
    fm = (model_q.size() == 16);
    em = (model_q.size() == 0);
    exp_rd = rd && !em;
    if (rd && !em) sb_q.push_back(model_q.pop_front());
    if (wr && !fm) model_q.push_back(wd);
    @(posedge clk);
    #1;
    exp_rd = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("wr_err", {31'h0, wr_err}, {31'h0, wr && fm});
    chk("rd_err", {31'h0, rd_err}, {31'h0, rd && em});
    chk("full", {31'h0, full}, {31'h0, model_q.size() == 16});
    chk("empty", {31'h0, empty}, {31'h0, model_q.size() == 0});
`ifdef SYNC_FIFO_COUNT_EN
    chk("count", {27'h0, count}, model_q.size());
`endif
    if (full && !prev_full) full_rises++;
    prev_full = full;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = 8'h00;
    #20;
    rst = 1'b0;
    #1;
    chk("rst_empty", {31'h0, empty}, 1);
    chk("rst_full", {31'h0, full}, 0);
    chk("rst_rdata", {24'h0, rdata}, 0);
    chk("rst_wr_err", {31'h0, wr_err}, 0);
    chk("rst_rd_err", {31'h0, rd_err}, 0);

    // Fill, overflow, drain, underflow
    for (int i = 1; i <= 16; i++) do_cycle(1, i[7:0], 0);
    do_cycle(1, 8'hFF, 0);
    for (int i = 0; i < 17; i++) do_cycle(0, 8'h00, 1);
    chk("drain_hold", {24'h0, rdata}, 32'h10);

    // Wrap the pointers
    for (int i = 0; i < 10; i++) do_cycle(1, 8'h50 + i[7:0], 0);
    for (int i = 0; i < 10; i++) do_cycle(0, 8'h00, 1);
    full_rises = 0;
    prev_full = full;
    for (int i = 0; i < 16; i++) do_cycle(1, 8'hA0 + i[7:0], 0);
    for (int i = 0; i < 16; i++) do_cycle(0, 8'h00, 1);
    chk("wrap_full_rises", full_rises, 1);
    chk("wrap_last", {24'h0, rdata}, 32'hAF);

    // Simultaneous read/write with 5 entries
    for (int i = 0; i < 5; i++) do_cycle(1, 8'h31 + i[7:0], 0);
    for (int i = 0; i < 3; i++) do_cycle(1, 8'h36 + i[7:0], 1);
    for (int i = 0; i < 5; i++) do_cycle(0, 8'h00, 1);
    chk("mid_last", {24'h0, rdata}, 32'h38);

    // Simultaneous when full: read wins, write rejected
    for (int i = 0; i < 16; i++) do_cycle(1, 8'hC0 + i[7:0], 0);
    do_cycle(1, 8'hEE, 1);
    chk("full_rw_rdata", {24'h0, rdata}, 32'hC0);
    for (int i = 0; i < 15; i++) do_cycle(0, 8'h00, 1);
    chk("full_rw_last", {24'h0, rdata}, 32'hCF);

    // Simultaneous when empty: write wins, read rejected
    do_cycle(1, 8'h77, 1);
    chk("empty_rw_hold", {24'h0, rdata}, 32'hCF);
    do_cycle(0, 8'h00, 1);
    chk("empty_rw_data", {24'h0, rdata}, 32'h77);

    // Asynchronous reset between edges
    for (int i = 0; i < 8; i++) do_cycle(1, 8'h90 + i[7:0], 0);
    #2;
    rst = 1'b1;
    model_q.delete();
    sb_q.delete();
    last_rdata = 8'h00;
    #1;
    chk("arst_empty", {31'h0, empty}, 1);
    chk("arst_full", {31'h0, full}, 0);
    chk("arst_rdata", {24'h0, rdata}, 0);
    @(negedge clk);
    rst = 1'b0;
    prev_full = 1'b0;
    do_cycle(0, 8'h00, 1);
    do_cycle(0, 8'h00, 0);
    do_cycle(0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock first-in-first-out buffer, WIDTH bits wide and DEPTH entries deep.
- Decouples a producer and a consumer that share one clock domain.
- Provides full/empty status and registered error flags for overflow (write while full) and underflow (read while empty) attempts.
- Read data is registered: one-cycle latency from an accepted read.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of storage entries; must be a power of two, at least 2.
- PTR_WIDTH, $clog2(DEPTH), address width; the internal pointers carry one extra wrap bit (PTR_WIDTH+1 bits).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- wdata  input  WIDTH  write data, sampled on the clk edge when a write is accepted.
- rdata  output  WIDTH  read data, registered.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- full  output  1  high when the FIFO holds DEPTH entries.
- empty  output  1  high when the FIFO holds 0 entries.
- wr_err  output  1  registered overflow flag.
- rd_err  output  1  registered underflow flag.
- Positional port order is clk, rst, wdata, rdata, wr_en, rd_en, full, empty, wr_err, rd_err.

Behaviour:
- Reset (asynchronous, rst=1), all effective immediately:
  - wr_ptr=0, rd_ptr=0, rdata=0, full=0, empty=1, wr_err=0, rd_err=0.
  - Storage array is not cleared.
- Pointers are PTR_WIDTH+1 bits.
  - Low PTR_WIDTH bits address the memory.
  - MSB toggles on each wrap-around.
- Status (combinational from the pointers):
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) AND (MSBs differ).
- Accepted write: wr_en=1 and full=0 at the rising edge.
  - mem[wr_ptr low bits] <= wdata.
  - wr_ptr increments modulo 2^(PTR_WIDTH+1).
- Accepted read: rd_en=1 and empty=0 at the rising edge.
  - rdata <= mem[rd_ptr low bits]; valid from that edge onward (one-cycle latency).
  - rd_ptr increments.
  - If no read is accepted, rdata holds its previous value.
- Full/empty are evaluated on the pre-edge state.
  - Full with wr_en=1 and rd_en=1: the read is accepted and the write is rejected. The write is rejected because the FIFO was full before the edge.
  - Empty with wr_en=1 and rd_en=1: the write is accepted and the read is rejected.
  - Neither full nor empty with both requested: both are accepted and occupancy is unchanged.
- wr_err: on each rising edge, wr_err <= (wr_en AND full). It is a one-cycle pulse per offending cycle and stays high while the condition persists. A rejected write does not modify memory or wr_ptr.
- rd_err: on each rising edge, rd_err <= (rd_en AND empty). A rejected read does not modify rdata or rd_ptr.
- Occupancy ranges 0..DEPTH inclusive; all DEPTH entries are usable.
- Data emerges in strict write order across any number of pointer wraps.
- Reset asserted mid-operation discards all contents immediately. The next read after reset without intervening writes produces rd_err.

Optional Feature:
- Macro SYNC_FIFO_COUNT_EN.
- When defined:
  - Adds output port count (PTR_WIDTH+1 bits), after rd_err.
  - count = wr_ptr - rd_ptr, modulo 2^(PTR_WIDTH+1), giving 0..DEPTH.
  - Combinational from the pointers; 0 in reset.
- When undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 20 ns then released -> empty=1, full=0, rdata=0, wr_err=0, rd_err=0.
- Fill: 16 consecutive writes of 0x01..0x10 -> full=1 after the 16th accepted edge, empty=0; 17th write of 0xFF -> wr_err=1 for that cycle, full stays 1, contents unchanged.
- Drain: 16 consecutive reads -> rdata sequence 0x01..0x10, each valid one edge after its read; empty=1 after the 16th; 17th read -> rd_err=1, rdata holds 0x10.
- Wrap: write 10, read 10, write 16 (0xA0..0xAF), read 16 -> data 0xA0..0xAF in order, full asserts exactly once.
- Simultaneous read and write:
  - With 5 entries -> count stays 5 and data order is preserved.
  - When full -> read accepted, write rejected with wr_err=1, occupancy becomes 15.
  - When empty -> write accepted, rd_err=1, occupancy becomes 1.
- Mid-operation reset: write 8 entries, assert rst asynchronously between edges -> empty=1 and full=0 immediately; next read gives rd_err=1.
